// File: rtl/temporizador_pkg.sv
// rtl/temporizador_pkg.sv - shared constants for the vending-machine timer bank
package temporizador_pkg;

    localparam int NUM_CH = 7;
    localparam int CNT_W  = 4;

    localparam int CH_BEBIDA   = 0;
    localparam int CH_MOEDA    = 1;
    localparam int CH_PRESSU   = 2;
    localparam int CH_AQUECI   = 3;
    localparam int CH_ENTRE    = 4;
    localparam int CH_ERRMOEDA = 5;
    localparam int CH_SENSOR   = 6;

    localparam int DEF_DUR_BEBIDA   = 10;
    localparam int DEF_DUR_MOEDA    = 10;
    localparam int DEF_DUR_PRESSU   = 2;
    localparam int DEF_DUR_AQUECI   = 10;
    localparam int DEF_DUR_ENTRE    = 2;
    localparam int DEF_DUR_ERRMOEDA = 6;
    localparam int DEF_DUR_SENSOR   = 6;

    function automatic bit dur_valida(input int dur);
        return (dur >= 1) && (dur <= (2 ** CNT_W) - 1);
    endfunction

endpackage

// File: rtl/canal_temporizador.sv
// rtl/canal_temporizador.sv - one saturating seconds counter with registered expiry flag
module canal_temporizador
    import temporizador_pkg::*;
#(
    parameter int DUR = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_rise,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_t
);

    localparam logic [CNT_W-1:0] DUR_C = CNT_W'(DUR);

    if (!dur_valida(DUR)) begin : g_dur_invalida
        $error("canal_temporizador: DUR must be in 1..15");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_t;
    logic [CNT_W-1:0] w_cnt_next;

    // A fresh rise always restarts from zero, even if a tick lands on the same edge.
    always_comb begin
        w_cnt_next = r_cnt;
        if (!i_en || i_rise) begin
            w_cnt_next = '0;
        end else if (i_tick && (r_cnt < DUR_C)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_t   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_t   <= i_en && (w_cnt_next == DUR_C);
        end
    end

    assign o_cnt = r_cnt;
    assign o_t   = r_t;

endmodule

// File: rtl/banco_temporizadores.sv
// rtl/banco_temporizadores.sv - seven-channel seconds timer bank with shared prescaler
module banco_temporizadores
    import temporizador_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DUR_BEBIDA   = DEF_DUR_BEBIDA,
    parameter int DUR_MOEDA    = DEF_DUR_MOEDA,
    parameter int DUR_PRESSU   = DEF_DUR_PRESSU,
    parameter int DUR_AQUECI   = DEF_DUR_AQUECI,
    parameter int DUR_ENTRE    = DEF_DUR_ENTRE,
    parameter int DUR_ERRMOEDA = DEF_DUR_ERRMOEDA,
    parameter int DUR_SENSOR   = DEF_DUR_SENSOR
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sec10_bebida,
    input  logic             sec10_moeda,
    input  logic             sec2_pressu,
    input  logic             sec10_aqueci,
    input  logic             sec2_entre,
    input  logic             sec6_errMoeda,
    input  logic             sec6_sensor,
    output logic             T10_bebida,
    output logic             T10_moeda,
    output logic             T2_pressu,
    output logic             T10_aqueci,
    output logic             T2_entre,
    output logic             T6_errMoeda,
    output logic             T6_sensor,
    output logic [CNT_W-1:0] restante,
    output logic             conflito
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam int DUR_A [NUM_CH] = '{DUR_BEBIDA, DUR_MOEDA, DUR_PRESSU, DUR_AQUECI,
                                      DUR_ENTRE, DUR_ERRMOEDA, DUR_SENSOR};

    if (CLK_HZ < 1) begin : g_clk_invalido
        $error("banco_temporizadores: CLK_HZ must be at least 1");
    end

    logic [NUM_CH-1:0]            w_en;
    logic [NUM_CH-1:0]            r_en_d;
    logic [NUM_CH-1:0]            w_rise;
    logic [NUM_CH-1:0]            w_t;
    logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
    logic [PRESC_W-1:0]           r_presc;
    logic                         w_any;
    logic                         w_any_rise;
    logic                         w_tick;
    logic [CNT_W-1:0]             w_restante;
    logic [CNT_W-1:0]             r_restante;
    logic                         r_conflito;

    assign w_en = {sec6_sensor, sec6_errMoeda, sec2_entre, sec10_aqueci,
                   sec2_pressu, sec10_moeda, sec10_bebida};

    assign w_rise     = w_en & ~r_en_d;
    assign w_any      = |w_en;
    assign w_any_rise = |w_rise;
    assign w_tick     = w_any && (r_presc == PRESC_MAX);

    // Any new start realigns the shared second so the starting channel gets a full one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d  <= '0;
            r_presc <= '0;
        end else begin
            r_en_d <= w_en;
            if (!w_any || w_any_rise || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
        canal_temporizador #(
            .DUR(DUR_A[g])
        ) u_canal (
            .clock  (clock),
            .reset_n(reset_n),
            .i_en   (w_en[g]),
            .i_rise (w_rise[g]),
            .i_tick (w_tick),
            .o_cnt  (w_cnt[g]),
            .o_t    (w_t[g])
        );
    end

    // Lowest-index active channel owns the display; scan downward so it wins.
    always_comb begin
        w_restante = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_en[i]) begin
                w_restante = CNT_W'(DUR_A[i]) - w_cnt[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_restante <= '0;
            r_conflito <= 1'b0;
        end else begin
            r_restante <= w_restante;
            r_conflito <= ($countones(w_en) > 1);
        end
    end

    assign T10_bebida  = w_t[CH_BEBIDA];
    assign T10_moeda   = w_t[CH_MOEDA];
    assign T2_pressu   = w_t[CH_PRESSU];
    assign T10_aqueci  = w_t[CH_AQUECI];
    assign T2_entre    = w_t[CH_ENTRE];
    assign T6_errMoeda = w_t[CH_ERRMOEDA];
    assign T6_sensor   = w_t[CH_SENSOR];
    assign restante    = r_restante;
    assign conflito    = r_conflito;

endmodule

// File: tb/tb_banco_temporizadores.sv
// tb/tb_banco_temporizadores.sv - directed self-checking bench for banco_temporizadores
module tb_banco_temporizadores;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] en = '0;
    logic [6:0] t;
    logic [3:0] restante;
    logic       conflito;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    banco_temporizadores #(
        .CLK_HZ(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sec10_bebida (en[0]),
        .sec10_moeda  (en[1]),
        .sec2_pressu  (en[2]),
        .sec10_aqueci (en[3]),
        .sec2_entre   (en[4]),
        .sec6_errMoeda(en[5]),
        .sec6_sensor  (en[6]),
        .T10_bebida   (t[0]),
        .T10_moeda    (t[1]),
        .T2_pressu    (t[2]),
        .T10_aqueci   (t[3]),
        .T2_entre     (t[4]),
        .T6_errMoeda  (t[5]),
        .T6_sensor    (t[6]),
        .restante     (restante),
        .conflito     (conflito)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) next_edge();
    endtask

    initial begin
        logic seen;
        int   k_hit;

        edges(3);
        reset_n = 1'b1;
        edges(50);
        check_eq("idle_t", t, 0);
        check_eq("idle_restante", restante, 0);
        check_eq("idle_conflito", conflito, 0);

        // pressu: 2 s at 4 cycles/s
        en[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            next_edge();
            check_eq($sformatf("pressu_t_e%0d", k), t, (k >= 8) ? 7'b0000100 : 7'b0);
            check_eq($sformatf("pressu_rest_e%0d", k), restante,
                     (k <= 4) ? 2 : ((k <= 8) ? 1 : 0));
        end
        check_eq("pressu_conflito", conflito, 0);
        en[2] = 1'b0;
        next_edge();
        check_eq("pressu_drop_t", t, 0);
        check_eq("pressu_drop_rest", restante, 0);

        // moeda: aborted run, then full restart
        en[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            next_edge();
            seen = seen | t[1];
        end
        check_eq("moeda_first_run_no_t", seen, 0);
        en[1] = 1'b0;
        next_edge();
        check_eq("moeda_drop_rest", restante, 0);
        en[1] = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            next_edge();
            if (k == 0)  check_eq("moeda_restart_rest", restante, 10);
            if (k == 39) check_eq("moeda_t_e39", t[1], 0);
            if (k == 40) check_eq("moeda_t_e40", t[1], 1);
        end
        en[1] = 1'b0;
        next_edge();
        check_eq("moeda_clear_t", t, 0);

        // sensor with asynchronous reset mid-count
        en[6] = 1'b1;
        edges(10);
        check_eq("sensor_rest_pre_reset", restante, 4);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("reset_async_t", t, 0);
        check_eq("reset_async_rest", restante, 0);
        check_eq("reset_async_conflito", conflito, 0);
        edges(2);
        reset_n = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            next_edge();
            if (k == 23) check_eq("sensor_t_e23", t[6], 0);
            if (k == 24) check_eq("sensor_t_e24", t[6], 1);
        end
        en[6] = 1'b0;
        next_edge();
        check_eq("sensor_clear_t", t, 0);

        // aqueci and entre together
        en[3] = 1'b1;
        en[4] = 1'b1;
        next_edge();
        check_eq("conf_e0", conflito, 1);
        for (int k = 1; k <= 40; k++) begin
            next_edge();
            if (k == 1)  check_eq("conf_rest_e1", restante, 10);
            if (k == 7)  check_eq("entre_t_e7", t[4], 0);
            if (k == 8)  check_eq("entre_t_e8", t[4], 1);
            if (k == 9)  check_eq("conf_rest_e9", restante, 8);
            if (k == 39) check_eq("aqueci_t_e39", t[3], 0);
            if (k == 40) begin
                check_eq("aqueci_t_e40", t[3], 1);
                check_eq("entre_t_held", t[4], 1);
                check_eq("conf_e40", conflito, 1);
            end
        end
        en[3] = 1'b0;
        en[4] = 1'b0;
        next_edge();
        check_eq("conf_clear", conflito, 0);
        check_eq("conf_clear_t", t, 0);

        // emulated FSM handshake: bebida expiry hands over to moeda
        en[0] = 1'b1;
        k_hit = -1;
        for (int k = 0; k < 60; k++) begin
            next_edge();
            if (t[0] && (k_hit < 0)) begin
                k_hit = k;
                break;
            end
        end
        check_eq("bebida_expiry_edge", k_hit, 40);
        en[0] = 1'b0;
        en[1] = 1'b1;
        next_edge();
        check_eq("fsm_bebida_cleared", t[0], 0);
        check_eq("fsm_conflito", conflito, 0);
        check_eq("fsm_moeda_rest", restante, 10);
        for (int k = 1; k <= 40; k++) begin
            next_edge();
            if (k == 39) check_eq("fsm_moeda_t_e39", t[1], 0);
            if (k == 40) check_eq("fsm_moeda_t_e40", t[1], 1);
        end
        en[1] = 1'b0;
        next_edge();
        check_eq("fsm_final_t", t, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
